// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller for NUM_DIGITS hex digits.
// Adds full hex decode, per-digit DP/blank/blink, leading-zero suppression,
// 16-level PWM brightness, a blank guard at the start of each digit slot,
// and a per-frame input snapshot.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned SCAN_DIV       = 65536,
  parameter int unsigned GUARD          = 256,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       digits_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          blink_phase,
  input  logic                          lz_en,
  input  logic [3:0]                    brightness,
  output logic [7:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_tick
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned W  = (SCAN_DIV - GUARD) / 16;

  // Reject parameter sets that break the slot arithmetic.
  if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || GUARD < 1 || GUARD >= SCAN_DIV ||
      ((SCAN_DIV - GUARD) % 16) != 0) begin : g_param_check
    $error("seg_scan_ctrl: illegal NUM_DIGITS/SCAN_DIV/GUARD combination");
  end

  logic [CW-1:0]                cnt, cnt_nxt;
  logic [IW-1:0]                idx, idx_nxt;
  logic                         snap;
  logic [NUM_DIGITS-1:0][3:0]   sh_digits;
  logic [NUM_DIGITS-1:0]        sh_dp;
  logic [NUM_DIGITS-1:0]        sh_blank;
  logic [NUM_DIGITS-1:0]        sh_blink;
  logic                         sh_lz;
  logic [3:0]                   sh_bright;
  logic [NUM_DIGITS-1:0]        lz_run;
  logic [31:0]                  win_end;
  logic                         win;
  logic [7:0]                   seg_on;
  logic [7:0]                   seg_nxt;
  logic [NUM_DIGITS-1:0]        an_nxt;

  // Active-high {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Slot counter and digit index advance.
  always_comb begin
    cnt_nxt = cnt + CW'(1);
    idx_nxt = idx;
    if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  assign snap = (cnt == '0) && (idx == '0);

  // lz_run[i] = shadow nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic run;
    run    = 1'b1;
    lz_run = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      run       = run & (sh_digits[i] == 4'h0);
      lz_run[i] = run;
    end
  end

  // PWM window: [GUARD, GUARD + (brightness+1)*W).
  assign win_end = GUARD + (32'(sh_bright) + 32'd1) * W;
  assign win     = (32'(cnt) >= GUARD) && (32'(cnt) < win_end);

  // Segment content priority and window gating, in logical (active-high) sense.
  always_comb begin
    seg_on = {sh_dp[idx], hex7(sh_digits[idx])};
    if (sh_blink[idx] && blink_phase) begin
      seg_on = '0;
    end else if (sh_blank[idx]) begin
      seg_on = '0;
    end else if (sh_lz && (idx != '0) && lz_run[idx]) begin
      seg_on = {sh_dp[idx], 7'h00};
    end
    seg_nxt = win ? seg_on : '0;
    an_nxt  = win ? (NUM_DIGITS'(1) << idx) : '0;
  end

  // Scan state and frame snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_blink  <= '0;
      sh_lz     <= 1'b0;
      sh_bright <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      if (snap) begin
        sh_digits <= digits_i;
        sh_dp     <= dp_i;
        sh_blank  <= blank_mask;
        sh_blink  <= blink_mask;
        sh_lz     <= lz_en;
        sh_bright <= brightness;
      end
    end
  end

  // Output register with pin polarity applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= {8{SEG_ACTIVE_LOW}};
      an_out     <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      scan_idx   <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_nxt ^ {8{SEG_ACTIVE_LOW}};
      an_out     <= an_nxt ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      scan_idx   <= idx;
      frame_tick <= snap;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed 7-segment scan controller for N hex digits. It sits between the clock/timekeeping datapath and the board's common-anode/cathode display pins. It adds several features to the fixed 6-digit BCD scanner:
- full hex decode;
- per-digit DP, blank and blink masks;
- leading-zero suppression;
- 16-level PWM brightness;
- an anti-ghosting guard interval;
- frame-coherent input snapshotting.

## Interface
- NUM_DIGITS, 8, number of digits scanned (2..16)
- SCAN_DIV, 65536, clk cycles per digit slot
- GUARD, 256, blank cycles at start of each slot; 1 <= GUARD < SCAN_DIV; (SCAN_DIV-GUARD) must be a multiple of 16 (elaboration check)
- SEG_ACTIVE_LOW, 1, segment pin polarity
- AN_ACTIVE_LOW, 1, anode pin polarity
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- digits_i  in  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]; digit 0 = rightmost
- dp_i  in  NUM_DIGITS  decimal point request per digit
- blank_mask  in  NUM_DIGITS  1 = digit segments+DP forced off, anode still scanned
- blink_mask  in  NUM_DIGITS  1 = digit participates in blink
- blink_phase  in  1  live blink level (e.g. 2 Hz square); 1 = blinking digits dark
- lz_en  in  1  leading-zero suppression enable
- brightness  in  4  PWM level 0..15
- seg_out  out  8  {dp,g,f,e,d,c,b,a}, registered
- an_out  out  NUM_DIGITS  one-hot digit enable, registered
- scan_idx  out  $clog2(NUM_DIGITS)  index of digit currently on an_out, registered
- frame_tick  out  1  one-cycle pulse at each frame snapshot, registered

## Operation
- Counters:
  - slot counter cnt counts 0..SCAN_DIV-1;
  - at cnt==SCAN_DIV-1, idx advances, wrapping NUM_DIGITS-1 -> 0.
- Snapshot:
  - in any cycle with cnt==0 && idx==0 (including the first cycle after reset), these inputs are copied into shadow registers: digits_i, dp_i, blank_mask, blink_mask, lz_en, brightness.
  - all display decisions use shadows, except blink_phase, which is sampled live every cycle.
- Slot phases, with W=(SCAN_DIV-GUARD)/16:
  - cnt<GUARD: guard; all anodes and segments inactive;
  - GUARD <= cnt < GUARD+(brightness+1)*W: anode idx active, segments driven;
  - remainder: anodes and segments inactive.
  - brightness=15 gives the full active window.
- Segment content for digit idx, in priority order:
  1. blink_mask[idx] && blink_phase: all 8 segments off.
  2. blank_mask[idx]: all 8 off.
  3. Leading zero (lz_en, idx>0, and shadow nibbles idx..NUM_DIGITS-1 all zero): a-g off, DP follows dp_i[idx].
  4. Otherwise: hex decode of the nibble (0-9, A, b, C, d, E, F), DP = dp_i[idx].
  - Digit 0 is never zero-suppressed.
- Polarity: logical "on" is inverted at the output register per SEG_ACTIVE_LOW / AN_ACTIVE_LOW.

## Timing
- Reset (rst=1 at an edge):
  - cnt=0, idx=0, shadows=0;
  - seg_out and an_out all inactive (all 1s when active-low);
  - scan_idx=0, frame_tick=0.
- Latency:
  - outputs after edge k reflect the cnt/idx/shadow state present during cycle k-1 (one register stage);
  - GUARD>=1 guarantees a freshly loaded snapshot is never displayed with stale content.
- Rates:
  - frame_tick asserts for one cycle every NUM_DIGITS*SCAN_DIV cycles;
  - first pulse is at the edge following the post-reset snapshot cycle.
- Input changes:
  - mid-frame changes to snapshotted inputs are invisible until the next frame_tick;
  - blink_phase changes take effect within one cycle.
- Reset mid-frame: next edge forces inactive outputs; scan restarts at idx 0 with a new snapshot.
- At most one an_out bit is active at any time; none during guard or PWM-off.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=36, GUARD=4 (W=2), both polarities active-low.

1. **Reset:** hold rst 3 cycles, release, brightness=15.
   - During reset: an_out=4'hF, seg_out=8'hFF.
   - an_out=4'b1110 first appears after the 5th edge following release.
   - scan_idx steps 0,1,2,3,0 every 36 cycles.
2. **Hex decode:** digits_i=16'hA5F0, dp_i=0, brightness=15.
   - Active seg_out per digit 0..3 = 8'hC0, 8'h8E, 8'h92, 8'h88.
   - Set dp_i=4'b0001: digit 0 reads 8'h40.
3. **PWM:** brightness=3.
   - Anode active for exactly 8 cycles per slot (cnt 4..11), inactive for the remaining 28.
   - brightness=0 gives 2 active cycles.
4. **Leading zero:** lz_en=1.
   - digits_i=16'h0070: digits 3,2 read 8'hFF; digit 1 reads 8'hF8; digit 0 reads 8'hC0.
   - digits_i=16'h0000: only digit 0 shows 8'hC0.
   - Anodes still scan all 4 digits.
5. **Snapshot coherency:** change digits_i from 16'h1234 to 16'h5678 while idx=1.
   - Remaining slots of the frame still show 1234.
   - 5678 appears only after frame_tick.
   - frame_tick period is exactly 144 cycles.
6. **Blink and blank:** blink_mask=4'b0011, blank_mask=4'b0100, dp_i=4'hF.
   - blink_phase=1: digits 0, 1, 2 read 8'hFF.
   - blink_phase=0: digits 0, 1 restore within 1 cycle; digit 2 stays 8'hFF.
   - Asserting rst mid-slot gives inactive outputs at the next edge.
